csr_access_unit: RTL
====================

# csr_access_unit

Sequencer for CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms), sitting between the decode/execute stage and the machine-mode CSR register file. It accepts one decoded request, reads the addressed CSR, and computes the read-modify-write value. It issues a single-cycle write strobe, checks privilege and read-only legality, and returns the old CSR value for rd, or an illegal-instruction indication.

## Interface
Parameters:
- ILLEGAL_CAUSE, 32'd2, mcause code returned on an illegal access.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low.
- req_valid_i  in  1  request valid from the execute stage.
- req_ready_o  out  1  unit can accept a request.
- req_op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 are invalid.
- req_csr_i  in  12  CSR address.
- req_rs1_data_i  in  32  rs1 value, used for register forms.
- req_uimm_i  in  5  rs1 field, zero-extended as the operand for immediate forms.
- req_rs1_zero_i  in  1  the rs1/uimm field is 0.
- priv_i  in  2  current privilege level (11 = M, 00 = U).
- csr_addr_o  out  12  address to the CSR register file.
- csr_w_data_o  out  32  write data to the CSR register file.
- csr_w_en_o  out  1  write strobe to the CSR register file.
- csr_data_i  in  32  combinational read data from the CSR register file.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rd_data_o  out  32  old CSR value, destined for rd.
- rsp_illegal_o  out  1  access was illegal; no write was performed.
- rsp_cause_o  out  32  ILLEGAL_CAUSE when rsp_illegal_o is 1, otherwise 0.

## Operation
- FSM states are IDLE, READ, WRITE and RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, capture op, csr, operand and priv, then go to READ.
- READ:
  - csr_addr_o = captured csr.
  - Capture csr_data_i as old.
  - Compute legality and the new value.
  - Go to WRITE if the access is legal and write_intent is set; otherwise go to RESP.
- Operand selection: src = op[2] ? {27'b0, uimm} : rs1_data.
- New value:
  - RW/RWI: new = src.
  - RS/RSI: new = old | src.
  - RC/RCI: new = old & ~src.
- write_intent = 1 for RW/RWI. For RS/RC/RSI/RCI, write_intent = !rs1_zero.
- Illegal when any of the following holds:
  - op is 000 or 100;
  - priv < csr[9:8];
  - csr[11:10] == 2'b11 and write_intent = 1.
- WRITE:
  - csr_w_en_o = 1 for exactly one cycle.
  - csr_w_data_o = new and csr_addr_o = csr.
  - Go to RESP.
- RESP:
  - rsp_valid_o = 1.
  - rsp_rd_data_o = old when legal, 0 when illegal.
  - Hold all rsp_* outputs stable until rsp_ready_i = 1, then return to IDLE.
- Exactly one write is issued per legal writing request. An illegal request never asserts csr_w_en_o.
- csr_addr_o holds the captured address from READ through RESP.

## Timing
- Reset values: req_ready_o = 1, csr_addr_o = 0, csr_w_data_o = 0, csr_w_en_o = 0, rsp_valid_o = 0, rsp_rd_data_o = 0, rsp_illegal_o = 0, rsp_cause_o = 0, state = IDLE.
- Request accepted at edge T: READ occupies cycle T+1 and WRITE occupies T+2.
  - With a write, rsp_valid_o rises at T+3.
  - Without a write (no write_intent, or illegal), rsp_valid_o rises at T+2.
- Handshake completing at edge E: IDLE is reached after E, and a new request can be accepted at edge E+1. The minimum issue interval is 4 cycles with a write and 3 without.
- req_ready_o = 0 in READ, WRITE and RESP; request inputs are ignored in those states.
- The write in WRITE is visible to the register file at the edge that ends WRITE.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately, including csr_w_en_o = 0 with no glitch-high.
  - The pending request is dropped and no deferred write is issued.
- rsp_ready_i held high in advance: RESP lasts exactly one cycle.

## Test plan
- CSRRW with mscratch = 0x0000_0000, rs1 = 0xDEAD_BEEF, priv = 11: one write strobe with data 0xDEAD_BEEF at T+2, and rsp_rd_data_o = 0 at T+3.
- CSRRS with rs1 = 0x0000_0008, old mie = 0x0000_0080: write data 0x0000_0088. Then CSRRCI with uimm = 8: write data 0x0000_0080, and rd = 0x0000_0088.
- CSRRS with rs1_zero = 1 on mcycle (0xB00): no csr_w_en_o, rsp_valid_o at T+2, and rd = the sampled counter value.
- CSRRW to mhartid (0xF14), or any access with priv = 00 to 0x300: rsp_illegal_o = 1, rsp_cause_o = 2, rd = 0, and csr_w_en_o never asserted.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles. rsp_* stays stable and req_ready_o stays 0, then IDLE is reached one cycle after the handshake.
- Assert reset_n low during WRITE: csr_w_en_o drops asynchronously and all outputs read their reset values. After release, a fresh CSRRW completes normally.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one CSR instruction (CSRRW/RS/RC and the
// immediate forms) through read, optional single write, and response.
// All outputs are registered. Each output's next value is decoded from the
// current state and the next state.
module csr_access_unit #(
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_csr_i,
  input  logic [31:0] req_rs1_data_i,
  input  logic [4:0]  req_uimm_i,
  input  logic        req_rs1_zero_i,
  input  logic [1:0]  priv_i,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_w_data_o,
  output logic        csr_w_en_o,
  input  logic [31:0] csr_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rd_data_o,
  output logic        rsp_illegal_o,
  output logic [31:0] rsp_cause_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  // Captured request fields
  logic [2:0]  op_r;
  logic [31:0] src_r;
  logic        rs1_zero_r;
  logic [1:0]  priv_r;

  // Output registers and their next values
  logic        req_ready_r,   req_ready_nxt_s;
  logic [11:0] csr_addr_r,    csr_addr_nxt_s;
  logic [31:0] csr_w_data_r,  csr_w_data_nxt_s;
  logic        csr_w_en_r,    csr_w_en_nxt_s;
  logic        rsp_valid_r,   rsp_valid_nxt_s;
  logic [31:0] rsp_rd_data_r, rsp_rd_data_nxt_s;
  logic        rsp_illegal_r, rsp_illegal_nxt_s;
  logic [31:0] rsp_cause_r,   rsp_cause_nxt_s;

  logic        write_intent_s;
  logic        illegal_s;
  logic [31:0] new_value_s;

  // Read-modify-write value selected by the low funct3 bits
  function automatic logic [31:0] rmw_value(input logic [2:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] src);
    case (op[1:0])
      2'b01:   rmw_value = src;
      2'b10:   rmw_value = old | src;
      2'b11:   rmw_value = old & ~src;
      default: rmw_value = 32'h0000_0000;
    endcase
  endfunction

  // Legality, write intent and new value, evaluated while in READ
  always_comb begin
    if (op_r[1:0] == 2'b01) begin
      write_intent_s = 1'b1;
    end else begin
      write_intent_s = !rs1_zero_r;
    end
    illegal_s = (op_r[1:0] == 2'b00) ||
                (priv_r < csr_addr_r[9:8]) ||
                ((csr_addr_r[11:10] == 2'b11) && write_intent_s);
    new_value_s = rmw_value(op_r, csr_data_i, src_r);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (!illegal_s && write_intent_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      WRITE:   state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Capture the request fields on acceptance; the operand is resolved here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= 3'b000;
      src_r      <= 32'h0000_0000;
      rs1_zero_r <= 1'b0;
      priv_r     <= 2'b00;
    end else if ((state_r == IDLE) && req_valid_i) begin
      op_r       <= req_op_i;
      src_r      <= req_op_i[2] ? {27'b0, req_uimm_i} : req_rs1_data_i;
      rs1_zero_r <= req_rs1_zero_i;
      priv_r     <= priv_i;
    end else begin
      op_r       <= op_r;
      src_r      <= src_r;
      rs1_zero_r <= rs1_zero_r;
      priv_r     <= priv_r;
    end
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    req_ready_nxt_s   = (state_nxt_s == IDLE);
    csr_addr_nxt_s    = csr_addr_r;
    csr_w_data_nxt_s  = csr_w_data_r;
    csr_w_en_nxt_s    = 1'b0;
    rsp_valid_nxt_s   = rsp_valid_r;
    rsp_rd_data_nxt_s = rsp_rd_data_r;
    rsp_illegal_nxt_s = rsp_illegal_r;
    rsp_cause_nxt_s   = rsp_cause_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          csr_addr_nxt_s    = req_csr_i;
          rsp_rd_data_nxt_s = 32'h0000_0000;
          rsp_illegal_nxt_s = 1'b0;
          rsp_cause_nxt_s   = 32'h0000_0000;
        end else begin
          csr_addr_nxt_s    = csr_addr_r;
        end
      end
      READ: begin
        rsp_illegal_nxt_s = illegal_s;
        if (illegal_s) begin
          rsp_rd_data_nxt_s = 32'h0000_0000;
          rsp_cause_nxt_s   = ILLEGAL_CAUSE;
        end else begin
          rsp_rd_data_nxt_s = csr_data_i;
          rsp_cause_nxt_s   = 32'h0000_0000;
        end
        if (state_nxt_s == WRITE) begin
          csr_w_en_nxt_s   = 1'b1;
          csr_w_data_nxt_s = new_value_s;
        end else begin
          rsp_valid_nxt_s  = 1'b1;
        end
      end
      WRITE: rsp_valid_nxt_s = 1'b1;
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt_s = 1'b0;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end
      default: rsp_valid_nxt_s = 1'b0;
    endcase
  end

  // Output registers; reset forces the write strobe low immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_r   <= 1'b1;
      csr_addr_r    <= 12'h000;
      csr_w_data_r  <= 32'h0000_0000;
      csr_w_en_r    <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rd_data_r <= 32'h0000_0000;
      rsp_illegal_r <= 1'b0;
      rsp_cause_r   <= 32'h0000_0000;
    end else begin
      req_ready_r   <= req_ready_nxt_s;
      csr_addr_r    <= csr_addr_nxt_s;
      csr_w_data_r  <= csr_w_data_nxt_s;
      csr_w_en_r    <= csr_w_en_nxt_s;
      rsp_valid_r   <= rsp_valid_nxt_s;
      rsp_rd_data_r <= rsp_rd_data_nxt_s;
      rsp_illegal_r <= rsp_illegal_nxt_s;
      rsp_cause_r   <= rsp_cause_nxt_s;
    end
  end

  assign req_ready_o   = req_ready_r;
  assign csr_addr_o    = csr_addr_r;
  assign csr_w_data_o  = csr_w_data_r;
  assign csr_w_en_o    = csr_w_en_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rd_data_o = rsp_rd_data_r;
  assign rsp_illegal_o = rsp_illegal_r;
  assign rsp_cause_o   = rsp_cause_r;

endmodule
